block_check_seq: RTL
====================

// Module: block_check_seq
// PURPOSE
//  Sequencer for the block checker: buffers a character string from a host,
//  then feeds it one character per cycle into the shared checker. Clears the
//  checker before each run and captures its verdict as pass plus a done pulse.
//  Sits between the host write port and the checker's clk/reset/in/result pins.
// PARAMETERS
//  AW     5    buffer address width; DEPTH = 1<<AW characters (default 32)
// PORTS
//  clk        in   1     system clock, rising edge
//  reset      in   1     asynchronous, active-low; whole block cleared while 0
//  wr_en      in   1     write wr_data into buffer (IDLE only)
//  wr_data    in   8     ASCII character to buffer
//  start      in   1     begin run over buffered chars (IDLE only)
//  busy       out  1     run in progress (CLR/FEED/TAIL/SAMPLE)
//  done       out  1     one-cycle pulse: pass is valid
//  pass       out  1     checker verdict of last run; holds until next done
//  cnt        out  AW+1  buffered character count, 0..DEPTH
//  ovf        out  1     sticky: write dropped because buffer was full
//  chk_reset  out  1     to checker reset, active-high, synchronous at checker
//  chk_in     out  8     to checker in
//  chk_result in   1     from checker result
// BEHAVIOUR
//  - Reset values: busy=0 done=0 pass=0 cnt=0 ovf=0 chk_reset=1 chk_in=8'h20;
//    state=IDLE, rd_ptr=0. All outputs are registered.
//  - FSM: IDLE -> CLR -> FEED -> [TAIL] -> SAMPLE -> IDLE.
//  - IDLE: chk_reset=0, chk_in=8'h20. wr_en with cnt<DEPTH: buf[cnt]<=wr_data,
//    cnt++. wr_en with cnt==DEPTH: data dropped, ovf<=1, cnt stays at DEPTH.
//    start: go to CLR and clear ovf. If start and wr_en are asserted in the
//    same cycle, start wins and the write is discarded.
//  - CLR: one cycle, chk_reset=1, chk_in=8'h20, rd_ptr<=0. If cnt==0, go to
//    TAIL/SAMPLE directly; otherwise go to FEED.
//  - FEED: chk_in=buf[rd_ptr], one character per cycle, no stalls. rd_ptr++.
//    After the character at cnt-1 is presented, go to TAIL (when the macro is
//    defined) or SAMPLE.
//  - TAIL: one cycle, chk_in=8'h20 (terminating space). Present only with
//    the macro defined.
//  - SAMPLE: chk_in=8'h20. chk_result reflects the last consumed character.
//    On exit: pass<=chk_result, done<=1 for exactly one cycle, busy<=0, cnt<=0,
//    state<=IDLE.
//  - Latency: start is sampled at edge E0; done is high after edge E0+cnt+2,
//    or E0+cnt+3 with the macro defined. busy is high from E0+1 until done rises.
//  - wr_en and start while busy are ignored. Writes do not set ovf while busy.
//  - Asynchronous reset mid-run: run aborts, buffer count is lost, no done
//    pulse. chk_reset stays 1 until reset is released, then drops to 0 (IDLE).
//  - Empty run (cnt==0): the checker only sees the clear, so pass equals the
//    checker's post-reset result (1 = balanced).
//  - cnt is AW+1 bits so the full count DEPTH is representable; rd_ptr is AW
//    bits and never wraps within a run.
// CONFIGURATION
//  BLOCK_SEQ_TAIL_SPACE_EN defined: TAIL state is compiled in. A space follows
//    the last buffered character, so a trailing "end" is terminated before
//    sampling.
//  BLOCK_SEQ_TAIL_SPACE_EN undefined: no TAIL state; SAMPLE follows FEED
//    directly.
// TESTING
//  1 write "begin end" (9 chars), start -> chk_reset pulses once; done after
//    E0+11 (+12 with macro); pass=1
//  2 write "end begin", start -> pass=0; cnt=0 after done; busy low at done
//  3 start with empty buffer -> done after E0+2 (+3 with macro); pass=1;
//    chk_in stays 8'h20
//  4 write 33 chars -> cnt=32, ovf=1; start -> ovf=0 at E0+1; 32 chars fed
//  5 reset=0 during FEED of "begin begin" -> busy=0, cnt=0, chk_reset=1, no done;
//    after release a new "begin end" run gives pass=1
//  6 start and wr_en in same IDLE cycle with cnt=3 -> run uses 3 chars; the
//    write is discarded

Source files
------------

// File: rtl/block_check_seq.sv
// -----------------------------------------------------------------------------
// block_check_seq
//
// Purpose:
//   Sequencer for the block checker. A host fills a character buffer through a
//   simple write port while the sequencer is idle. On start, the sequencer
//   clears the checker with a one-cycle synchronous reset, then streams the
//   buffered characters into it, one per cycle with no stalls. Finally it
//   samples the checker's verdict, presents it on pass, and pulses done for one
//   cycle. The buffer count is cleared so the next string can be loaded.
//
//   Run sequence: IDLE -> CLR -> FEED -> [TAIL] -> SAMPLE -> IDLE
//   With an empty buffer, CLR skips FEED and goes straight to TAIL/SAMPLE.
//
// Configuration:
//   BLOCK_SEQ_TAIL_SPACE_EN  defined: a TAIL state feeds one space after the
//                            last buffered character. A trailing word is then
//                            terminated before the verdict is sampled.
//                            undefined: SAMPLE follows FEED directly.
//
// Parameters:
//   AW          buffer address width; DEPTH = 1 << AW characters
//
// Ports:
//   clk         in   1     system clock, rising edge
//   reset       in   1     asynchronous, active-low; whole block cleared while 0
//   wr_en       in   1     write wr_data into the buffer (honoured in IDLE only)
//   wr_data     in   8     ASCII character to buffer
//   start       in   1     begin a run over the buffered characters (IDLE only)
//   busy        out  1     run in progress (CLR/FEED/TAIL/SAMPLE)
//   done        out  1     one-cycle pulse; pass is valid
//   pass        out  1     checker verdict of the last run; holds until next done
//   cnt         out  AW+1  buffered character count, 0..DEPTH
//   ovf         out  1     sticky; a write was dropped because the buffer was full
//   chk_reset   out  1     checker reset, active-high, synchronous at the checker
//   chk_in      out  8     checker character input
//   chk_result  in   1     checker result
//
// All outputs are registered. Each one is loaded from the value it must have
// in the next state, so it is aligned with that state.
// -----------------------------------------------------------------------------
module block_check_seq #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   cnt,
    output logic          ovf,
    output logic          chk_reset,
    output logic [7:0]    chk_in,
    input  logic          chk_result
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);
    localparam logic [7:0]  SPACE   = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_FEED   = 3'd2,
`ifdef BLOCK_SEQ_TAIL_SPACE_EN
        ST_TAIL   = 3'd3,
`endif
        ST_SAMPLE = 3'd4
    } state_t;

    // State entered once the last character has been presented. This is also
    // the state CLR jumps to when the buffer is empty.
`ifdef BLOCK_SEQ_TAIL_SPACE_EN
    localparam state_t ST_AFTER_FEED = ST_TAIL;
`else
    localparam state_t ST_AFTER_FEED = ST_SAMPLE;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_cnt;
    logic            r_ovf;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic            r_chk_reset;
    logic [7:0]      r_chk_in;
    logic [7:0]      r_buf [DEPTH];

    // ------------------------------------------------------------------
    // Next-state / control wires
    // ------------------------------------------------------------------
    state_t          w_state_nxt;
    logic [AW-1:0]   w_rd_ptr_nxt;
    logic            w_wr_accept;
    logic            w_ovf_set;
    logic            w_ovf_clr;
    logic            w_done_nxt;
    logic            w_cnt_clr;
    logic            w_buf_full;
    logic            w_last_char;
    logic [7:0]      w_chk_in_nxt;

    assign w_buf_full  = (r_cnt == CNT_MAX);
    // rd_ptr never exceeds cnt-1 while feeding, so it never wraps, even at
    // cnt == DEPTH.
    assign w_last_char = ({1'b0, r_rd_ptr} == (r_cnt - (AW + 1)'(1)));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal is given a default before the case statement, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_accept  = 1'b0;
        w_ovf_set    = 1'b0;
        w_ovf_clr    = 1'b0;
        w_done_nxt   = 1'b0;
        w_cnt_clr    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // start has priority. A write in the same cycle is discarded
                // so the string being run cannot change.
                if (start) begin
                    w_state_nxt = ST_CLR;
                    w_ovf_clr   = 1'b1;
                end else if (wr_en) begin
                    if (w_buf_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_wr_accept = 1'b1;
                    end
                end
            end

            ST_CLR: begin
                w_rd_ptr_nxt = '0;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_AFTER_FEED;
                end else begin
                    w_state_nxt = ST_FEED;
                end
            end

            ST_FEED: begin
                if (w_last_char) begin
                    w_state_nxt = ST_AFTER_FEED;
                end else begin
                    w_rd_ptr_nxt = r_rd_ptr + AW'(1);
                end
            end

`ifdef BLOCK_SEQ_TAIL_SPACE_EN
            ST_TAIL: begin
                w_state_nxt = ST_SAMPLE;
            end
`endif

            ST_SAMPLE: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
                w_cnt_clr   = 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The character on chk_in is registered. Look up the character for the
    // next state now, so it appears together with that state.
    assign w_chk_in_nxt = (w_state_nxt == ST_FEED) ? r_buf[w_rd_ptr_nxt] : SPACE;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments.
    // Every register then samples the values from before the edge, whatever
    // order the statements are in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_chk_reset <= 1'b1;
            r_chk_in    <= SPACE;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            r_chk_reset <= (w_state_nxt == ST_CLR);
            r_chk_in    <= w_chk_in_nxt;

            // In SAMPLE the checker has consumed the last character.
            if (r_state == ST_SAMPLE) begin
                r_pass <= chk_result;
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_wr_accept) begin
                r_cnt <= r_cnt + (AW + 1)'(1);
            end

            if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Character buffer
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset. Only entries below cnt are ever
    // read, and cnt itself is reset, so stale contents can never be observed.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_buf[r_cnt[AW-1:0]] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign cnt       = r_cnt;
    assign ovf       = r_ovf;
    assign chk_reset = r_chk_reset;
    assign chk_in    = r_chk_in;

endmodule
